// File: rtl/fetch_controller_if.sv
// Instruction-memory bus between the fetch controller and the instruction ROM.
// The memory answers combinationally: imem_instr is the word at imem_addr >> 2.
interface fetch_controller_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;

    modport master (output imem_addr, input imem_instr);
    modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, reads instruction memory and registers
// the fetched word into IF/ID, with stall, single-bubble redirect and end-of-memory halt.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_DEPTH = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_controller_if.master imem,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4,
    output logic [31:0]        if_instr,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic [31:0] instr_q, instr_d;
    logic        halted_q, halted_d;
    logic [31:0] count_q, count_d;
    logic [31:0] target;

    // Low address bits are dropped by masking so every redirect lands on a word boundary.
    assign target = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            ifpc_q   <= '0;
            ifpc4_q  <= '0;
            instr_q  <= '0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            ifpc_q   <= ifpc_d;
            ifpc4_q  <= ifpc4_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        ifpc_d   = ifpc_q;
        ifpc4_d  = ifpc4_q;
        instr_d  = instr_q;
        halted_d = halted_q;
        count_d  = count_q;

        case (state_q)
            BOOT: begin
                valid_d = 1'b0;
                state_d = FETCH;
                if (redirect) begin
                    pc_d = target;
                end
            end
            FETCH, HALT: begin
                // Redirect beats stall, and is the only way out of HALT short of reset.
                if (redirect) begin
                    pc_d     = target;
                    valid_d  = 1'b0;
                    state_d  = FETCH;
                    halted_d = 1'b0;
                end else if (stall || state_q == HALT) begin
                    state_d = state_q;
                end else if (pc_q < MEM_BYTES) begin
                    instr_d = imem.imem_instr;
                    ifpc_d  = pc_q;
                    ifpc4_d = pc_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    if (count_q != 32'hFFFF_FFFF) begin
                        count_d = count_q + 32'd1;
                    end
                end else begin
                    valid_d  = 1'b0;
                    state_d  = HALT;
                    halted_d = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    assign imem.imem_addr = pc_q;
    assign if_valid       = valid_q;
    assign if_pc          = ifpc_q;
    assign if_pc_plus4    = ifpc4_q;
    assign if_instr       = instr_q;
    assign halted         = halted_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: reset, sequential fetch, stall, redirect,
// end-of-memory halt and mid-run reset, against hand-computed expectations.
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];
    int          tests_run;
    int          tests_failed;

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_PC  (32'h0000_0000),
        .MEM_DEPTH (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_instr    (if_instr),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    // Out-of-range addresses return a poison word so an illegal issue is visible.
    assign bus.imem_instr = (bus.imem_addr < 32'h400) ? mem[bus.imem_addr[9:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
        reset       = rst;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIssue(input string tag, input logic [31:0] pc, input logic [31:0] count);
        checkOutput({tag, " valid"}, {31'b0, if_valid}, 32'd1);
        checkOutput({tag, " pc"}, if_pc, pc);
        checkOutput({tag, " pc4"}, if_pc_plus4, pc + 32'd4);
        checkOutput({tag, " instr"}, if_instr, 32'h2008_0000 + (pc >> 2));
        checkOutput({tag, " count"}, fetch_count, count);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h2008_0000 + 32'(i);
        end
        reset       = 1'b1;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #2;

        // Reset held two cycles with stall and redirect also asserted
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        checkOutput("rst valid", {31'b0, if_valid}, 32'd0);
        checkOutput("rst pc", if_pc, 32'd0);
        checkOutput("rst pc4", if_pc_plus4, 32'd0);
        checkOutput("rst instr", if_instr, 32'd0);
        checkOutput("rst halted", {31'b0, halted}, 32'd0);
        checkOutput("rst count", fetch_count, 32'd0);
        checkOutput("rst addr", bus.imem_addr, 32'd0);

        // BOOT bubble, then sequential fetch 0,4,8
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("boot valid", {31'b0, if_valid}, 32'd0);
        checkOutput("boot addr", bus.imem_addr, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIssue("seq0", 32'h0, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIssue("seq4", 32'h4, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIssue("seq8", 32'h8, 32'd3);

        // Stall for three cycles while if_pc=8
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkIssue("stall", 32'h8, 32'd3);
            checkOutput("stall addr", bus.imem_addr, 32'hC);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIssue("resume", 32'hC, 32'd4);

        // Redirect overrides stall; low address bits are dropped
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h43);
        checkOutput("rdr valid", {31'b0, if_valid}, 32'd0);
        checkOutput("rdr addr", bus.imem_addr, 32'h40);
        checkOutput("rdr hold pc", if_pc, 32'hC);
        checkOutput("rdr count", fetch_count, 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIssue("rdr tgt", 32'h40, 32'd5);

        // Run off the end of memory
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h3F8);
        checkOutput("eom bubble", {31'b0, if_valid}, 32'd0);
        checkOutput("eom addr", bus.imem_addr, 32'h3F8);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIssue("eom 3f8", 32'h3F8, 32'd6);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIssue("eom 3fc", 32'h3FC, 32'd7);
        checkOutput("eom pc4", if_pc_plus4, 32'h400);
        checkOutput("eom pre-halt", {31'b0, halted}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, (i % 3) == 1, 1'b0, 32'h0);
            checkOutput("halt valid", {31'b0, if_valid}, 32'd0);
            checkOutput("halt flag", {31'b0, halted}, 32'd1);
            checkOutput("halt addr", bus.imem_addr, 32'h400);
            checkOutput("halt count", fetch_count, 32'd7);
        end

        // Redirect leaves HALT
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("unhalt flag", {31'b0, halted}, 32'd0);
        checkOutput("unhalt valid", {31'b0, if_valid}, 32'd0);
        checkOutput("unhalt addr", bus.imem_addr, 32'h0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        end
        checkIssue("run 20", 32'h20, 32'd16);

        // Reset mid-run discards everything in flight
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mid valid", {31'b0, if_valid}, 32'd0);
        checkOutput("mid pc", if_pc, 32'd0);
        checkOutput("mid instr", if_instr, 32'd0);
        checkOutput("mid count", fetch_count, 32'd0);
        checkOutput("mid addr", bus.imem_addr, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mid boot", {31'b0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIssue("refetch", 32'h0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
